// File: rtl/typed_link_pkg.sv
// rtl/typed_link_pkg.sv - shared types and helpers for the typed serializer/deserializer link
package typed_link_pkg;

   typedef enum logic {LINK_IDLE, LINK_SEND} link_state_e;

   // Chunk 0 of every word carries the least significant bits.
   localparam bit LINK_LSB_FIRST = 1'b1;

   function automatic int link_num_chunks(input int tw, input int cw);
      return (tw + cw - 1) / cw;
   endfunction

endpackage

// File: rtl/link_chunk_counter.sv
// rtl/link_chunk_counter.sv - chunk index counter with clear/increment and last-chunk flag
module link_chunk_counter #(
   parameter int NCHUNK = 4,
   parameter int CW     = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          inc,
   output logic [CW-1:0] idx,
   output logic          is_last
);

   localparam logic [CW-1:0] LAST_IDX = CW'(NCHUNK - 1);

   assign is_last = (idx == LAST_IDX);

   // clear wins so a new word always starts at chunk 0; inc on the last chunk wraps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
      end else if (clear) begin
         idx <= '0;
      end else if (inc) begin
         idx <= is_last ? '0 : idx + 1'b1;
      end
   end

endmodule

// File: rtl/typed_serializer.sv
// rtl/typed_serializer.sv - splits one packed word of type T into CHUNK_W-bit chunks on a valid/ready channel
module typed_serializer
   import typed_link_pkg::*;
#(
   parameter type T       = logic [7:0],
   parameter int  CHUNK_W = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  T                   in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CHUNK_W-1:0] out_data,
   output logic               out_first,
   output logic               out_last,
   output logic               busy
);

   localparam int TW     = $bits(T);
   localparam int NCHUNK = link_num_chunks(TW, CHUNK_W);
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int SW     = NCHUNK * CHUNK_W;
   localparam logic [CW-1:0] LAST_IDX = CW'(NCHUNK - 1);

   link_state_e   state_q, state_d;
   logic [SW-1:0] word_q;
   logic [SW-1:0] capture_word;
   logic [CW-1:0] idx;
   logic [CW-1:0] chunk_pos;
   logic          is_last;
   logic          xfer;
   logic          accept;

   assign out_valid = (state_q == LINK_SEND);
   assign busy      = out_valid;
   assign out_first = out_valid && (idx == '0);
   assign out_last  = out_valid && is_last;
   assign xfer      = out_valid && out_ready;
   assign in_ready  = (state_q == LINK_IDLE) || (out_last && out_ready);
   assign accept    = in_valid && in_ready;

   // Pad with zeros above TW; signed fields inside T are never extended.
   always_comb begin
      capture_word         = '0;
      capture_word[TW-1:0] = in_data;
   end

   always_comb begin
      chunk_pos = LINK_LSB_FIRST ? idx : LAST_IDX - idx;
      out_data  = '0;
      if (out_valid) begin
         out_data = word_q[int'(chunk_pos) * CHUNK_W +: CHUNK_W];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         LINK_IDLE: if (accept) state_d = LINK_SEND;
         LINK_SEND: if (xfer && is_last && !accept) state_d = LINK_IDLE;
         default:   state_d = LINK_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LINK_IDLE;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) word_q <= capture_word;
      end
   end

   link_chunk_counter #(
      .NCHUNK (NCHUNK),
      .CW     (CW)
   ) u_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (accept),
      .inc     (xfer),
      .idx     (idx),
      .is_last (is_last)
   );

endmodule

// File: tb/tb_typed_serializer.sv
// tb/tb_typed_serializer.sv - directed self-checking bench for typed_serializer
module tb_typed_serializer;

   typedef struct packed {
      logic              x;
      logic signed [1:0] b;
   } small_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_first, a_out_last, a_busy;
   logic [7:0] a_in_data;
   logic [1:0] a_out_data;

   logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_first, s_out_last, s_busy;
   small_t     s_in_data;
   logic [1:0] s_out_data;

   logic       w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_first, w_out_last, w_busy;
   logic [7:0] w_in_data;
   logic [7:0] w_out_data;

   logic [1:0] exp4 [8];

   typed_serializer #(.T(logic [7:0]), .CHUNK_W(2)) u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .out_first(a_out_first), .out_last(a_out_last), .busy(a_busy)
   );

   typed_serializer #(.T(small_t), .CHUNK_W(2)) u_dut_s (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
      .out_first(s_out_first), .out_last(s_out_last), .busy(s_busy)
   );

   typed_serializer #(.T(logic [7:0]), .CHUNK_W(8)) u_dut_w (
      .clk(clk), .rst_n(rst_n),
      .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
      .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
      .out_first(w_out_first), .out_last(w_out_last), .busy(w_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic [1:0] d, input logic f, input logic l);
      check({tag, ".valid"}, 32'(a_out_valid), 32'd1);
      check({tag, ".data"},  32'(a_out_data),  32'(d));
      check({tag, ".first"}, 32'(a_out_first), 32'(f));
      check({tag, ".last"},  32'(a_out_last),  32'(l));
   endtask

   initial begin
      exp4 = '{2'd2, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd3, 2'd0};
      a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = 8'h00;
      s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_data = '0;
      w_in_valid = 1'b0; w_out_ready = 1'b0; w_in_data = 8'h00;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst.valid", 32'(a_out_valid), 32'd0);
      check("rst.data",  32'(a_out_data),  32'd0);
      check("rst.first", 32'(a_out_first), 32'd0);
      check("rst.last",  32'(a_out_last),  32'd0);
      check("rst.busy",  32'(a_busy),      32'd0);
      rst_n = 1'b1;
      #1;
      check("rst.in_ready", 32'(a_in_ready), 32'd1);

      // T1: 8'hB4 -> 0,1,3,2
      a_in_data = 8'hB4; a_in_valid = 1'b1; a_out_ready = 1'b1;
      tick();
      a_in_valid = 1'b0; a_in_data = 8'h00;
      #1;
      chk_a("t1c0", 2'd0, 1'b1, 1'b0);
      check("t1.busy", 32'(a_busy), 32'd1);
      tick(); chk_a("t1c1", 2'd1, 1'b0, 1'b0);
      tick(); chk_a("t1c2", 2'd3, 1'b0, 1'b0);
      tick(); chk_a("t1c3", 2'd2, 1'b0, 1'b1);
      check("t1.in_ready_last", 32'(a_in_ready), 32'd1);
      tick();
      check("t1.idle_valid", 32'(a_out_valid), 32'd0);
      check("t1.idle_busy",  32'(a_busy),      32'd0);

      // T2: struct 3'b101, CHUNK_W=2 -> 01 then 01 (zero pad, no sign extension)
      s_in_data = small_t'(3'b101); s_in_valid = 1'b1; s_out_ready = 1'b1;
      tick();
      s_in_valid = 1'b0;
      #1;
      check("t2c0.valid", 32'(s_out_valid), 32'd1);
      check("t2c0.data",  32'(s_out_data),  32'd1);
      check("t2c0.first", 32'(s_out_first), 32'd1);
      check("t2c0.last",  32'(s_out_last),  32'd0);
      tick();
      check("t2c1.data",  32'(s_out_data),  32'd1);
      check("t2c1.first", 32'(s_out_first), 32'd0);
      check("t2c1.last",  32'(s_out_last),  32'd1);
      tick();
      check("t2.idle_valid", 32'(s_out_valid), 32'd0);

      // T3: backpressure on chunk 1 for three cycles
      a_in_data = 8'hB4; a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      #1;
      chk_a("t3c0", 2'd0, 1'b1, 1'b0);
      tick();
      a_out_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk_a("t3hold", 2'd1, 1'b0, 1'b0);
         check("t3hold.in_ready", 32'(a_in_ready), 32'd0);
         tick();
      end
      a_out_ready = 1'b1;
      #1;
      chk_a("t3c1", 2'd1, 1'b0, 1'b0);
      tick(); chk_a("t3c2", 2'd3, 1'b0, 1'b0);
      tick(); chk_a("t3c3", 2'd2, 1'b0, 1'b1);
      tick();
      check("t3.idle_valid", 32'(a_out_valid), 32'd0);

      // T4: back-to-back 8'h12, 8'h34 with no bubble
      a_in_data = 8'h12; a_in_valid = 1'b1;
      tick();
      a_in_data = 8'h34;
      for (int i = 0; i < 8; i++) begin
         a_in_valid = (i < 4);
         #1;
         chk_a("t4", exp4[i], (i % 4) == 0, (i % 4) == 3);
         check("t4.in_ready", 32'(a_in_ready), 32'((i % 4) == 3));
         tick();
      end
      check("t4.idle_valid", 32'(a_out_valid), 32'd0);

      // T5: CHUNK_W=8, one chunk per word
      w_in_data = 8'hA5; w_in_valid = 1'b1; w_out_ready = 1'b1;
      tick();
      w_in_data = 8'h3C;
      #1;
      check("t5a.valid",    32'(w_out_valid), 32'd1);
      check("t5a.data",     32'(w_out_data),  32'hA5);
      check("t5a.first",    32'(w_out_first), 32'd1);
      check("t5a.last",     32'(w_out_last),  32'd1);
      check("t5a.in_ready", 32'(w_in_ready),  32'd1);
      tick();
      w_in_valid = 1'b0;
      #1;
      check("t5b.valid", 32'(w_out_valid), 32'd1);
      check("t5b.data",  32'(w_out_data),  32'h3C);
      check("t5b.first", 32'(w_out_first), 32'd1);
      check("t5b.last",  32'(w_out_last),  32'd1);
      tick();
      check("t5.idle_valid", 32'(w_out_valid), 32'd0);

      // T6: asynchronous reset mid-word, then a clean 8'hFF
      a_in_data = 8'hB4; a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      #1;
      chk_a("t6c0", 2'd0, 1'b1, 1'b0);
      tick();
      chk_a("t6c1", 2'd1, 1'b0, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      check("t6.rst_valid", 32'(a_out_valid), 32'd0);
      check("t6.rst_busy",  32'(a_busy),      32'd0);
      check("t6.rst_data",  32'(a_out_data),  32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      check("t6.post_valid",    32'(a_out_valid), 32'd0);
      check("t6.post_in_ready", 32'(a_in_ready),  32'd1);
      a_in_data = 8'hFF; a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk_a("t6ff", 2'd3, i == 0, i == 3);
         tick();
      end
      check("t6.idle_valid", 32'(a_out_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/typed_serializer.md
Name: typed_serializer

Overview:
- Transmit side of a typed point-to-point link.
- Accepts one value of parameter type T per handshake and emits it as a sequence of CHUNK_W-bit chunks, LSB chunk first, on a valid/ready channel.
- T may be any packed type: logic vector, packed array, or packed struct.
- Sits between type-parameterized datapath blocks and narrow transport. A matching deserializer reassembles T at the far end.

Parameters:
- T, default logic [7:0]: type of the word carried. Must be packed.
- CHUNK_W, default 2: output chunk width in bits. Must be >= 1.
- Derived localparam TW = $bits(T).
- Derived localparam NCHUNK = ceil(TW / CHUNK_W).
- Derived localparam CW = max(1, $clog2(NCHUNK)).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- in_valid  input  1  a word is offered on in_data.
- in_ready  output  1  serializer accepts in_data this cycle.
- in_data  input  T  word to send.
- out_valid  output  1  out_data holds a valid chunk.
- out_ready  input  1  downstream accepts the chunk.
- out_data  output  CHUNK_W  current chunk.
- out_first  output  1  current chunk is chunk 0 of its word.
- out_last  output  1  current chunk is chunk NCHUNK-1 of its word.
- busy  output  1  a word is held (state SEND).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, idx=0, shift register=0.
  - out_valid=0, out_data=0, out_first=0, out_last=0, busy=0.
  - in_ready=1 once rst_n deasserts.
- States:
  - IDLE: in_ready=1, out_valid=0. When in_valid=1, capture {pad zeros, in_data} into an NCHUNK*CHUNK_W-bit register, set idx=0, go to SEND.
  - SEND: out_valid=1. out_data = register bits [idx*CHUNK_W +: CHUNK_W]. out_first=(idx==0). out_last=(idx==NCHUNK-1).
- Transfers in SEND:
  - Transfer = out_valid && out_ready.
  - Transfer and not last: idx <= idx+1.
  - Transfer and last, with in_valid=1: capture the new word, idx <= 0, stay in SEND. No bubble.
  - Transfer and last, with in_valid=0: go to IDLE.
- in_ready = (state==IDLE) || (state==SEND && out_last && out_ready).
  - The combinational out_ready -> in_ready path is intended.
  - There is no combinational in_valid -> out_valid path.
- Latency: word accepted at edge N; chunk 0 is valid in cycle N+1. Minimum NCHUNK cycles per word; sustained throughput is 1 chunk per cycle.
- Stability: while out_valid=1 and out_ready=0, out_data, out_first and out_last hold unchanged.
- in_data is sampled only on accept; later changes are ignored.
- Padding: when TW is not a multiple of CHUNK_W, the upper bits of the last chunk are 0. The sign of T is never extended.
- NCHUNK==1: every chunk has out_first=out_last=1. idx stays 0.
- Reset mid-word: the partially sent word is dropped with no further chunks. Restart from IDLE.
- busy equals (state==SEND).

Decomposition:
- Package typed_link_pkg holds:
  - function link_num_chunks(int tw, int cw), returning ceil(tw/cw);
  - typedef enum logic {LINK_IDLE, LINK_SEND} link_state_e;
  - the chunk-order constant LINK_LSB_FIRST.
- The deserializer shares this package.
- One sub-module, link_chunk_counter (params NCHUNK, CW): idx register with inc/clear inputs and an is_last output. It is reused by the deserializer.
- Word capture, mux and FSM stay in typed_serializer.

Test Plan:
1. T=logic[7:0], CHUNK_W=2, in_data=8'hB4, out_ready=1 -> chunks 0,1,3,2 in 4 consecutive cycles; out_first on the 1st, out_last on the 4th; then busy=0.
2. T=struct packed {logic x; logic signed [1:0] b;}, CHUNK_W=2, value 3'b101 -> NCHUNK=2; chunks 2'b01 then 2'b01 (bit2 plus zero pad); no sign extension.
3. Backpressure: 8'hB4 with out_ready low for 3 cycles while chunk 1 is presented -> out_data=1 and out_first=0 stable for those cycles; chunk 1 completes on the first cycle out_ready=1; the total sequence is unchanged.
4. Back-to-back: words 8'h12 then 8'h34 with in_valid held and out_ready=1 -> 8 consecutive valid cycles giving chunks 2,0,1,0,0,1,3,0; in_ready=1 in cycle 4.
5. T=logic[7:0], CHUNK_W=8, words 8'hA5 and 8'h3C back-to-back -> one chunk per cycle, out_first=out_last=1 each.
6. rst_n pulsed low after chunk 1 of 8'hB4 -> out_valid=0 immediately, asynchronously; after release, a new word 8'hFF yields chunks 3,3,3,3 with no remnant of 8'hB4.
